// File: rtl/prach_fft_bitrev.sv
// Bit-reversal reorder stage for the PRACH DIT FFT: ping-pong RAM, output paced by next frame's input.
// Optional mid-frame resync error counter enabled by PRACH_BITREV_ERR_CNT_EN.
module prach_fft_bitrev #(
    parameter int unsigned NUM_FFT_LENGTH = 6,
    localparam int unsigned DW = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] din_dr,
    input  logic signed [DW-1:0] din_di,
    input  logic                 din_dv,
    input  logic                 sync_in,
    input  logic                 din_dv_ahead,
    input  logic                 sync_ahead_in,
    output logic signed [DW-1:0] dout_dr,
    output logic signed [DW-1:0] dout_di,
    output logic                 dout_dv,
    output logic                 sync_out,
    output logic                 dout_dv_ahead,
    output logic                 sync_ahead_out
`ifdef PRACH_BITREV_ERR_CNT_EN
    ,
    output logic [15:0]          sync_err_cnt
`endif
);

    localparam int unsigned AW = NUM_FFT_LENGTH;
    localparam int unsigned N  = 1 << NUM_FFT_LENGTH;
    localparam int unsigned MW = 2 * DW;

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_cnt, cnt_nxt;
    logic            wr_bank, bank_nxt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            resync;
    logic            emit;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   rd_addr;
    logic            rd_bank;
    logic [MW-1:0]   mem [2*N];
    logic [MW-1:0]   ram_q;
    logic [MW-1:0]   data_hold;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        return {<<{x}};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write-side sequencing: frame start, resync, wrap/bank swap and output launch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wr_cnt;
        bank_nxt  = wr_bank;
        wr_en     = 1'b0;
        wr_addr   = wr_cnt;
        resync    = 1'b0;
        emit      = 1'b0;
        if (din_dv) begin
            case (state)
                IDLE: begin
                    if (sync_in) begin
                        wr_en     = 1'b1;
                        wr_addr   = '0;
                        cnt_nxt   = AW'(1);
                        state_nxt = FILL;
                    end
                end
                default: begin
                    wr_en = 1'b1;
                    if (sync_in && (wr_cnt != '0)) begin
                        resync    = 1'b1;
                        wr_addr   = '0;
                        cnt_nxt   = AW'(1);
                        state_nxt = FILL;
                    end else begin
                        emit    = (state == STREAM);
                        cnt_nxt = wr_cnt + AW'(1);
                        if (wr_cnt == AW'(N - 1)) begin
                            bank_nxt  = ~wr_bank;
                            state_nxt = STREAM;
                        end
                    end
                end
            endcase
        end
    end

    // The read launched now serves the next sample, so it uses the post-update count and bank.
    assign rd_idx  = sync_ahead_in ? '0 : cnt_nxt;
    assign rd_addr = bitrev(rd_idx);
    assign rd_bank = ~bank_nxt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= {din_dr, din_di};
        end
        if (din_dv_ahead) begin
            ram_q <= mem[{rd_bank, rd_addr}];
        end
        if (din_dv) begin
            data_hold <= ram_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt         <= '0;
            wr_bank        <= 1'b0;
            dout_dv_ahead  <= 1'b0;
            sync_ahead_out <= 1'b0;
            dout_dv        <= 1'b0;
            sync_out       <= 1'b0;
            dout_dr        <= '0;
            dout_di        <= '0;
        end else begin
            wr_cnt         <= cnt_nxt;
            wr_bank        <= bank_nxt;
            dout_dv_ahead  <= emit;
            sync_ahead_out <= emit && (wr_cnt == '0);
            dout_dv        <= dout_dv_ahead;
            sync_out       <= sync_ahead_out;
            if (dout_dv_ahead) begin
                {dout_dr, dout_di} <= data_hold;
            end
        end
    end

`ifdef PRACH_BITREV_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_cnt <= '0;
        end else if (resync && (sync_err_cnt != 16'hFFFF)) begin
            sync_err_cnt <= sync_err_cnt + 16'd1;
        end
    end
`else
    logic unused_resync;
    assign unused_resync = resync;
`endif

endmodule
